// File: rtl/n_bit_adder_pkg.sv
// Shared constants for the registered ripple-carry adder.
//   ADDER_W_DEFAULT : default operand/sum width used by n_bit_adder.
package n_bit_adder_pkg;

  localparam int unsigned ADDER_W_DEFAULT = 4;

endpackage

// File: rtl/n_bit_adder_full_adder_cell.sv
// One-bit full adder cell; the ripple chain in n_bit_adder is built from these.
// Ports:
//   a_i, b_i : operand bits
//   cin_i    : carry into this bit
//   sum_o    : sum bit
//   cout_o   : carry out of this bit
module full_adder_cell (
  input  logic a_i,
  input  logic b_i,
  input  logic cin_i,
  output logic sum_o,
  output logic cout_o
);

  logic prop;

  always_comb begin
    prop   = a_i ^ b_i;
    sum_o  = prop ^ cin_i;
    cout_o = (a_i & b_i) | (cin_i & prop);
  end

endmodule

// File: rtl/n_bit_adder.sv
// N-bit ripple-carry adder with a single registered output stage.
// Ports:
//   clk       : clock, registers update on the rising edge
//   rst_n     : asynchronous active-low reset, clears all outputs
//   input1    : operand A (unsigned or two's complement)
//   input2    : operand B
//   carry_in  : carry into bit 0
//   answer    : registered (input1 + input2 + carry_in) mod 2^N
//   carry_out : registered carry out of bit N-1
//   overflow  : registered two's-complement overflow flag
module n_bit_adder
  import n_bit_adder_pkg::*;
#(
  parameter int unsigned N = ADDER_W_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] input1,
  input  logic [N-1:0] input2,
  input  logic         carry_in,
  output logic [N-1:0] answer,
  output logic         carry_out,
  output logic         overflow
);

  // carry[i] is the carry into bit i; carry[N] is the final carry out.
  logic [N:0]   carry;
  logic [N-1:0] sum;

  logic [N-1:0] answer_d, answer_q;
  logic         carry_out_d, carry_out_q;
  logic         overflow_d, overflow_q;

  assign carry[0] = carry_in;

  for (genvar i = 0; i < N; i++) begin : gen_chain
    full_adder_cell u_cell (
      .a_i   (input1[i]),
      .b_i   (input2[i]),
      .cin_i (carry[i]),
      .sum_o (sum[i]),
      .cout_o(carry[i+1])
    );
  end

  always_comb begin
    answer_d    = sum;
    carry_out_d = carry[N];
    // Signed overflow: carry into the sign bit differs from carry out of it.
    // For N = 1 the carry into the sign bit is carry_in itself.
    overflow_d  = carry[N] ^ carry[N-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      answer_q    <= '0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      answer_q    <= answer_d;
      carry_out_q <= carry_out_d;
      overflow_q  <= overflow_d;
    end
  end

  assign answer    = answer_q;
  assign carry_out = carry_out_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_n_bit_adder.sv
// Self-checking bench for n_bit_adder at widths 4, 8 and 1.
module tb_n_bit_adder;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  logic [3:0] a4, b4, ans4;
  logic       ci4, co4, ov4;
  logic [7:0] a8, b8, ans8;
  logic       ci8, co8, ov8;
  logic [0:0] a1, b1, ans1;
  logic       ci1, co1, ov1;

  int n_tests = 0;
  int n_fail  = 0;

  n_bit_adder #(.N(4)) u_dut4 (
    .clk      (clk),
    .rst_n    (rst_n),
    .input1   (a4),
    .input2   (b4),
    .carry_in (ci4),
    .answer   (ans4),
    .carry_out(co4),
    .overflow (ov4)
  );

  n_bit_adder #(.N(8)) u_dut8 (
    .clk      (clk),
    .rst_n    (rst_n),
    .input1   (a8),
    .input2   (b8),
    .carry_in (ci8),
    .answer   (ans8),
    .carry_out(co8),
    .overflow (ov8)
  );

  n_bit_adder #(.N(1)) u_dut1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .input1   (a1),
    .input2   (b1),
    .carry_in (ci1),
    .answer   (ans1),
    .carry_out(co1),
    .overflow (ov1)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: integer sum for {carry_out, answer}; overflow when the signed
  // sum falls outside the N-bit two's-complement range. Packed {ovf, cout, sum}.
  function automatic longint model(input int n, input longint a, input longint b,
                                   input longint ci);
    longint half, s, sa, sb, ss;
    longint ovf;
    half = longint'(1) << (n - 1);
    s    = a + b + ci;
    sa   = (a >= half) ? a - 2 * half : a;
    sb   = (b >= half) ? b - 2 * half : b;
    ss   = sa + sb + ci;
    ovf  = ((ss >= half) || (ss < -half)) ? 1 : 0;
    return (ovf << (n + 1)) | (((s >> n) & 1) << n) | (s & (2 * half - 1));
  endfunction

  // Expected value is {overflow, carry_out, answer} taken from the test plan.
  task automatic vec4(input string tag, input logic [3:0] a, input logic [3:0] b,
                      input logic ci, input logic [5:0] exp);
    a4  = a;
    b4  = b;
    ci4 = ci;
    @(posedge clk);
    #1;
    check_eq(tag, {58'd0, ov4, co4, ans4}, {58'd0, exp});
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_w4"}, {58'd0, ov4, co4, ans4}, 64'd0);
    check_eq({tag, "_w8"}, {54'd0, ov8, co8, ans8}, 64'd0);
    check_eq({tag, "_w1"}, {61'd0, ov1, co1, ans1}, 64'd0);
  endtask

  task automatic rand_cycle();
    longint e4, e8, e1;
    a4  = 4'($urandom);
    b4  = 4'($urandom);
    ci4 = 1'($urandom_range(0, 1));
    a8  = 8'($urandom);
    b8  = 8'($urandom);
    ci8 = 1'($urandom_range(0, 1));
    a1  = 1'($urandom_range(0, 1));
    b1  = 1'($urandom_range(0, 1));
    ci1 = 1'($urandom_range(0, 1));
    e4  = model(4, longint'(a4), longint'(b4), longint'(ci4));
    e8  = model(8, longint'(a8), longint'(b8), longint'(ci8));
    e1  = model(1, longint'(a1), longint'(b1), longint'(ci1));
    @(posedge clk);
    #1;
    check_eq("rand_w4", {58'd0, ov4, co4, ans4}, e4);
    check_eq("rand_w8", {54'd0, ov8, co8, ans8}, e8);
    check_eq("rand_w1", {61'd0, ov1, co1, ans1}, e1);
  endtask

  initial begin
    longint e;
    rst_n = 1'b0;
    a4 = 4'b1010; b4 = 4'b0110; ci4 = 1'b0;
    a8 = 8'hff;   b8 = 8'h01;   ci8 = 1'b1;
    a1 = 1'b1;    b1 = 1'b1;    ci1 = 1'b1;

    // Outputs must clear without any clock edge.
    #1;
    check_all_zero("reset_async");
    @(posedge clk);
    #1;
    check_all_zero("reset_edge");

    rst_n = 1'b1;
    vec4("first_after_reset", 4'b1010, 4'b0110, 1'b0, 6'b01_0000);
    vec4("seq_1000_0110",     4'b1000, 4'b0110, 1'b0, 6'b00_1110);
    vec4("seq_1000_0000",     4'b1000, 4'b0000, 1'b0, 6'b00_1000);
    vec4("seq_0100_0000",     4'b0100, 4'b0000, 1'b0, 6'b00_0100);
    vec4("seq_0100_1111",     4'b0100, 4'b1111, 1'b0, 6'b01_0011);
    vec4("seq_1101_1111",     4'b1101, 4'b1111, 1'b0, 6'b01_1100);
    vec4("cin_1101_1111",     4'b1101, 4'b1111, 1'b1, 6'b01_1101);
    vec4("cin_1101_0101",     4'b1101, 4'b0101, 1'b1, 6'b01_0011);
    vec4("cin_0111_0101",     4'b0111, 4'b0101, 1'b1, 6'b10_1101);
    vec4("cin0_0111_0101",    4'b0111, 4'b0101, 1'b0, 6'b10_1100);
    vec4("cin0_0111_1100",    4'b0111, 4'b1100, 1'b0, 6'b01_0011);
    vec4("ext_all_ones",      4'b1111, 4'b1111, 1'b1, 6'b01_1111);
    vec4("ext_all_zero",      4'b0000, 4'b0000, 1'b0, 6'b00_0000);
    vec4("ext_pos_ovf",       4'b0111, 4'b0001, 1'b0, 6'b10_1000);
    vec4("ext_neg_ovf",       4'b1000, 4'b1000, 1'b0, 6'b11_0000);

    // Inputs moving between edges must not reach the outputs.
    a4 = 4'b0101; b4 = 4'b0011; ci4 = 1'b1;
    #3;
    check_eq("hold_between_edges", {58'd0, ov4, co4, ans4}, {58'd0, 6'b11_0000});

    // Mid-stream async reset while answer = 0011.
    vec4("pre_reset_0011",    4'b0111, 4'b1100, 1'b0, 6'b01_0011);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("midreset_async");
    @(posedge clk);
    #1;
    check_all_zero("midreset_hold1");
    @(posedge clk);
    #1;
    check_all_zero("midreset_hold2");
    rst_n = 1'b1;

    // Exhaustive sweep at widths 4 and 1.
    for (int x = 0; x < 16; x++) begin
      for (int y = 0; y < 16; y++) begin
        for (int c = 0; c < 2; c++) begin
          a4  = 4'(x);
          b4  = 4'(y);
          ci4 = 1'(c);
          e   = model(4, longint'(x), longint'(y), longint'(c));
          @(posedge clk);
          #1;
          check_eq("sweep_w4", {58'd0, ov4, co4, ans4}, e);
        end
      end
    end
    for (int k = 0; k < 8; k++) begin
      a1  = 1'(k >> 2);
      b1  = 1'(k >> 1);
      ci1 = 1'(k);
      e   = model(1, longint'(a1), longint'(b1), longint'(ci1));
      @(posedge clk);
      #1;
      check_eq("sweep_w1", {61'd0, ov1, co1, ans1}, e);
    end

    for (int k = 0; k < 1000; k++) begin
      rand_cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/n_bit_adder.md
Name: n_bit_adder

Overview:
- Parameterised N-bit ripple-carry adder with a registered result stage.
- Sums two N-bit operands plus a carry-in and produces the N-bit sum, carry-out and a signed-overflow flag, all registered.
- Used as a datapath building block, for example in multiplier partial-product accumulation chains.
- Core is a chain of N one-bit full-adder cells.

Parameters:
- N, 4, operand and sum width in bits; legal range N >= 1.

Ports:
- clk  input  1  system clock; all registers update on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- input1  input  N  operand A, treated as unsigned or two's complement.
- input2  input  N  operand B.
- carry_in  input  1  carry into bit 0.
- answer  output  N  registered sum bits, (input1 + input2 + carry_in) mod 2^N.
- carry_out  output  1  registered carry out of bit N-1.
- overflow  output  1  registered two's-complement overflow flag.

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset:
  - While rst_n = 0: answer = 0, carry_out = 0, overflow = 0, immediately, independent of clk.
  - After rst_n deasserts, the first rising edge of clk loads a valid result.
- Combinational core:
  - c[0] = carry_in.
  - For i = 0..N-1: s[i] = input1[i] ^ input2[i] ^ c[i].
  - c[i+1] = (input1[i] & input2[i]) | (c[i] & (input1[i] ^ input2[i])).
  - {c[N], s} must equal input1 + input2 + carry_in, computed at N+1 bits with zero-extended operands.
- Overflow: ovf = c[N] ^ c[N-1]. For N = 1, c[0] is the carry_in term.
- Register stage:
  - Every rising clk edge with rst_n = 1: answer <= s, carry_out <= c[N], overflow <= ovf.
  - Latency is exactly 1 cycle. Throughput is one new operand set per cycle.
  - There is no enable and no handshake; outputs reflect the inputs sampled at the most recent edge.
- Boundary conditions:
  - All-ones + all-ones + 1 gives answer = all ones and carry_out = 1.
  - All-zeros + all-zeros + 0 gives answer = 0, carry_out = 0, overflow = 0.
  - A carry_in change alone updates the result at the next edge.
- Reset mid-operation: outputs clear asynchronously. Any in-flight sum is discarded, with no partial update.
- Inputs changing between edges have no effect on the outputs until the next edge. The core is purely combinational and holds no state.
- No latches. No X on the outputs after reset when the inputs are driven.

Decomposition:
- Shared package:
  - default width constant ADDER_W_DEFAULT = 4.
  - no typedefs needed beyond logic vectors.
- Sub-module full_adder_cell (a, b, cin -> sum, cout): N instances in a generate loop form the ripple chain.
- Top level holds the carry vector, the overflow XOR and the output register.

Test Plan (N = 4, each line is one cycle apart; expected outputs one edge after apply):
- Reset asserted with input1 = 1010, input2 = 0110 -> answer = 0000, carry_out = 0, overflow = 0 while rst_n = 0. Release, then apply 1010 + 0110 + 0 -> answer 0000, carry_out 1, overflow 0.
- Sequence with cin = 0:
  - 1000 + 0110 -> 1110, carry_out 0.
  - 1000 + 0000 -> 1000, carry_out 0.
  - 0100 + 0000 -> 0100, carry_out 0.
  - 0100 + 1111 -> 0011, carry_out 1.
  - 1101 + 1111 -> 1100, carry_out 1, overflow 0.
- Carry-in effect:
  - 1101 + 1111 + 1 -> 1101, carry_out 1.
  - 1101 + 0101 + 1 -> 0011, carry_out 1.
  - 0111 + 0101 + 1 -> 1101, carry_out 0, overflow 1.
  - then cin = 0: 0111 + 0101 -> 1100, overflow 1.
  - 0111 + 1100 + 0 -> 0011, carry_out 1, overflow 0.
- Extremes:
  - 1111 + 1111 + 1 -> 1111, carry_out 1.
  - 0000 + 0000 + 0 -> 0000, carry_out 0.
  - 0111 + 0001 + 0 -> 1000, overflow 1.
  - 1000 + 1000 + 0 -> 0000, carry_out 1, overflow 1.
- Async reset mid-stream: drop rst_n between edges while answer = 0011 -> outputs go to 0 immediately without a clock edge, and hold 0 through subsequent edges while rst_n = 0.
- Randomised, 1000 cycles, plus exhaustive sweep for N = 4 and a rerun with N = 8 and N = 1 -> each registered {carry_out, answer} equals the reference sum of the previous cycle's inputs. Overflow matches the sign rule: inputs share a sign and the sum sign differs.
